// File: rtl/echo_request_m2p.sv
// ----------------------------------------------------------------------------
// echo_request_m2p
// Host-side initiator for the EchoRequest interface. Each say / say2 / setLeds
// method call is marshalled into one pipe word (16-bit tag + 128-bit payload),
// buffered in a small FIFO and issued on pipe_enq.
//
// Ports
//   CLK, nRST                       clock, async active-low reset
//   method_say__ENA/_v/__RDY        say(v[31:0])
//   method_say2__ENA/_a/_b/__RDY    say2(a[15:0], b[15:0])
//   method_setLeds__ENA/_v/__RDY    setLeds(v[7:0])
//   pipe_enq__ENA/_v/__RDY          outgoing pipe word (144 bits)
//   sent_count                      words issued since reset (wraps)
//   multi_err                       sticky: more than one method strobed at once
// ----------------------------------------------------------------------------
module echo_request_m2p #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 16,
    parameter int PAYW  = 128
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 method_say__ENA,
    input  logic [31:0]          method_say_v,
    output logic                 method_say__RDY,
    input  logic                 method_say2__ENA,
    input  logic [15:0]          method_say2_a,
    input  logic [15:0]          method_say2_b,
    output logic                 method_say2__RDY,
    input  logic                 method_setLeds__ENA,
    input  logic [7:0]           method_setLeds_v,
    output logic                 method_setLeds__RDY,
    output logic                 pipe_enq__ENA,
    output logic [TAGW+PAYW-1:0] pipe_enq_v,
    input  logic                 pipe_enq__RDY,
    output logic [31:0]          sent_count,
    output logic                 multi_err
);

    localparam int WORDW = TAGW + PAYW;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    localparam logic [TAGW-1:0] TAG_SAY  = TAGW'(0);
    localparam logic [TAGW-1:0] TAG_SAY2 = TAGW'(1);
    localparam logic [TAGW-1:0] TAG_LEDS = TAGW'(2);

    logic [WORDW-1:0] mem_q [DEPTH];
    logic [WORDW-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      sent_count_q, sent_count_d;
    logic             multi_err_q, multi_err_d;

    logic             not_full;
    logic             non_empty;
    logic             accept;
    logic             issue;
    logic [1:0]       ena_cnt;
    logic [WORDW-1:0] enc_word;

    // Word encoding; priority say > say2 > setLeds when several strobe together.
    always_comb begin
        enc_word = '0;
        if (method_say__ENA) begin
            enc_word[WORDW-1 -: TAGW] = TAG_SAY;
            enc_word[PAYW-1 -: 32]    = method_say_v;
        end else if (method_say2__ENA) begin
            enc_word[WORDW-1 -: TAGW] = TAG_SAY2;
            enc_word[PAYW-1 -: 16]    = method_say2_a;
            enc_word[PAYW-17 -: 16]   = method_say2_b;
        end else if (method_setLeds__ENA) begin
            enc_word[WORDW-1 -: TAGW] = TAG_LEDS;
            enc_word[PAYW-1 -: 8]     = method_setLeds_v;
        end
    end

    always_comb begin
        // Fullness is judged on the registered count only, so a word draining
        // this cycle never frees a slot for a same-cycle call.
        not_full  = (count_q < CW'(DEPTH));
        non_empty = (count_q != '0);
        ena_cnt   = {1'b0, method_say__ENA} + {1'b0, method_say2__ENA}
                  + {1'b0, method_setLeds__ENA};
        accept    = not_full && (ena_cnt != 2'd0);
        issue     = non_empty && pipe_enq__RDY;

        mem_d = mem_q;
        if (accept) mem_d[wr_ptr_q] = enc_word;

        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = issue  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({accept, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        sent_count_d = issue ? sent_count_q + 32'd1 : sent_count_q;
        multi_err_d  = multi_err_q || (ena_cnt > 2'd1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sent_count_q <= '0;
            multi_err_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sent_count_q <= sent_count_d;
            multi_err_q  <= multi_err_d;
        end
    end

    // RDY is gated by nRST directly so it drops the moment reset is asserted.
    assign method_say__RDY     = nRST && not_full;
    assign method_say2__RDY    = nRST && not_full;
    assign method_setLeds__RDY = nRST && not_full;

    assign pipe_enq__ENA = issue;
    assign pipe_enq_v    = non_empty ? mem_q[rd_ptr_q] : '0;
    assign sent_count    = sent_count_q;
    assign multi_err     = multi_err_q;

endmodule

// File: tb/tb_echo_request_m2p.sv
// ----------------------------------------------------------------------------
// tb_echo_request_m2p
// Directed scenarios plus randomized traffic for echo_request_m2p, checked
// every cycle against a queue-based reference model of the method-to-pipe
// marshaller.
// ----------------------------------------------------------------------------
module tb_echo_request_m2p;

    localparam int DEPTH = 4;

    logic         clk_sys = 1'b0;
    logic         rst_n   = 1'b0;
    logic         say_ena = 1'b0, say2_ena = 1'b0, leds_ena = 1'b0;
    logic [31:0]  say_v   = '0;
    logic [15:0]  say2_a  = '0, say2_b = '0;
    logic [7:0]   leds_v  = '0;
    logic         say_rdy, say2_rdy, leds_rdy;
    logic         enq_ena;
    logic [143:0] enq_v;
    logic         enq_rdy = 1'b0;
    logic [31:0]  sent_count;
    logic         multi_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [143:0] mdl_q[$];
    logic [31:0]  mdl_sent  = '0;
    logic         mdl_multi = 1'b0;

    always #5 clk_sys = ~clk_sys;

    echo_request_m2p #(.DEPTH(DEPTH)) dut (
        .CLK                 (clk_sys),
        .nRST                (rst_n),
        .method_say__ENA     (say_ena),
        .method_say_v        (say_v),
        .method_say__RDY     (say_rdy),
        .method_say2__ENA    (say2_ena),
        .method_say2_a       (say2_a),
        .method_say2_b       (say2_b),
        .method_say2__RDY    (say2_rdy),
        .method_setLeds__ENA (leds_ena),
        .method_setLeds_v    (leds_v),
        .method_setLeds__RDY (leds_rdy),
        .pipe_enq__ENA       (enq_ena),
        .pipe_enq_v          (enq_v),
        .pipe_enq__RDY       (enq_rdy),
        .sent_count          (sent_count),
        .multi_err           (multi_err)
    );

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge against
    // the model, advance the model, then cross the rising edge.
    task automatic cycle(input bit s, input bit s2, input bit l, input bit pr,
                         input logic [31:0] sv, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] lv);
        logic         exp_rdy, exp_ena;
        logic [143:0] exp_v;
        int           n_ena;
        say_ena = s; say2_ena = s2; leds_ena = l; enq_rdy = pr;
        say_v = sv; say2_a = a; say2_b = b; leds_v = lv;
        @(negedge clk_sys);
        exp_rdy = (mdl_q.size() < DEPTH);
        exp_ena = (mdl_q.size() != 0) && pr;
        exp_v   = (mdl_q.size() != 0) ? mdl_q[0] : 144'd0;
        chk("say_rdy",    {143'd0, say_rdy},  {143'd0, exp_rdy});
        chk("say2_rdy",   {143'd0, say2_rdy}, {143'd0, exp_rdy});
        chk("leds_rdy",   {143'd0, leds_rdy}, {143'd0, exp_rdy});
        chk("enq_ena",    {143'd0, enq_ena},  {143'd0, exp_ena});
        chk("enq_v",      enq_v,              exp_v);
        chk("sent_count", {112'd0, sent_count}, {112'd0, mdl_sent});
        chk("multi_err",  {143'd0, multi_err},  {143'd0, mdl_multi});
        if (exp_ena) begin
            void'(mdl_q.pop_front());
            mdl_sent++;
        end
        n_ena = int'(s) + int'(s2) + int'(l);
        if (exp_rdy && n_ena != 0) begin
            if (s)       mdl_q.push_back({16'd0, sv, 96'd0});
            else if (s2) mdl_q.push_back({16'd1, a, b, 96'd0});
            else         mdl_q.push_back({16'd2, lv, 120'd0});
        end
        if (n_ena > 1) mdl_multi = 1'b1;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input bit pr);
        cycle(0, 0, 0, pr, '0, '0, '0, '0);
    endtask

    // Assert reset mid-cycle, check outputs collapse at once, release later.
    task automatic do_reset(input bit pr_during);
        say_ena = 0; say2_ena = 0; leds_ena = 0;
        #2;
        enq_rdy = pr_during;
        rst_n   = 1'b0;
        #1;
        chk("rst_enq_ena", {143'd0, enq_ena}, 144'd0);
        chk("rst_enq_v",   enq_v,             144'd0);
        chk("rst_rdy",     {141'd0, say_rdy, say2_rdy, leds_rdy}, 144'd0);
        chk("rst_sent",    {112'd0, sent_count}, 144'd0);
        chk("rst_multi",   {143'd0, multi_err},  144'd0);
        mdl_q.delete();
        mdl_sent  = '0;
        mdl_multi = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #3;
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        do_reset(1'b0);

        // 1: single say
        cycle(1, 0, 0, 1, 32'hDEADBEEF, '0, '0, '0);
        idle(1);
        idle(1);
        chk("t1_sent", {112'd0, sent_count}, 144'd1);

        // 2: say2 then setLeds, in order
        cycle(0, 1, 0, 1, '0, 16'h1234, 16'hABCD, '0);
        cycle(0, 0, 1, 1, '0, '0, '0, 8'h5A);
        idle(1);
        idle(1);

        // 3: fill with pipe stalled, 5th call ignored, then drain
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 32'h1000_0000 + 32'(i), '0, '0, '0);
        chk("t3_full_rdy", {143'd0, say_rdy}, 144'd0);
        for (int i = 0; i < 6; i++) idle(1);

        // 4: say + setLeds together
        cycle(1, 0, 1, 1, 32'hCAFE_F00D, '0, '0, 8'h77);
        idle(1);
        idle(1);
        chk("t4_multi", {143'd0, multi_err}, 144'd1);
        do_reset(1'b0);

        // 5: three words buffered, reset mid-stream with pipe ready
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0, 16'(i), 16'hBEEF, '0);
        do_reset(1'b1);
        idle(1);
        idle(1);

        // 6: full FIFO, alternate drain / enqueue across the pointer wrap
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 32'hA000_0000 + 32'(i), '0, '0, '0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            idle(1);
            cycle(1, 0, 0, 0, 32'hB000_0000 + 32'(i), '0, '0, '0);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1);
        chk("t6_sent", {112'd0, sent_count}, 144'(3 * DEPTH));

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit s, s2, l, pr;
            s  = ($urandom_range(0, 3) == 0);
            s2 = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 3) == 0);
            pr = ($urandom_range(0, 2) != 0);
            // simultaneous strobes only where a call is legal
            if (mdl_q.size() >= DEPTH && (int'(s) + int'(s2) + int'(l)) > 1) begin
                s2 = 0;
                l  = 0;
            end
            if (n % 2 == 0 && (int'(s) + int'(s2) + int'(l)) > 1) begin
                s2 = 0;
                l  = 0;
            end
            cycle(s, s2, l, pr, $urandom(), 16'($urandom()), 16'($urandom()), 8'($urandom()));
            if (n == 700) do_reset(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
